// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch BCD time datapath.
package stopwatch_pkg;

  localparam int DIGIT_W   = 4;
  localparam int TIME_W    = 16;
  localparam int NUM_DIGITS = 4;

  localparam int SEC_O_MAX = 9;
  localparam int SEC_T_MAX = 5;
  localparam int MIN_O_MAX = 9;
  localparam int MIN_T_MAX = 5;

  localparam int SEC_O_LSB = 0;
  localparam int SEC_T_LSB = 4;
  localparam int MIN_O_LSB = 8;
  localparam int MIN_T_LSB = 12;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [TIME_W-1:0]  time_t;

  // Digit index 0 is seconds-ones, 3 is minutes-tens.
  function automatic int digit_max(input int idx);
    case (idx)
      0:       return SEC_O_MAX;
      1:       return SEC_T_MAX;
      2:       return MIN_O_MAX;
      default: return MIN_T_MAX;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counting 0..MAX, carrying out when it wraps.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   inc,
  output digit_t q,
  output logic   carry
);

  localparam digit_t MAX_D = DIGIT_W'(MAX);

  digit_t q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q_reg <= '0;
    end else if (inc) begin
      q_reg <= (q_reg == MAX_D) ? '0 : q_reg + 4'd1;
    end
  end

  assign q     = q_reg;
  assign carry = inc & (q_reg == MAX_D);

endmodule

// File: rtl/stopwatch_counter.sv
// BCD MM:SS elapsed-time counter with prescaler, lap-freezable display copy
// and registered second/rollover pulses.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_en,
  input  logic        lap,
  input  logic        clr_n,
  output logic [15:0] live_bcd,
  output logic [15:0] disp_bcd,
  output logic        sec_tick,
  output logic        rollover
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]         presc_reg;
  logic                  advance;
  logic [NUM_DIGITS:0]   inc_chain;
  digit_t                digit_q [NUM_DIGITS];
  time_t                 disp_reg;
  logic                  sec_tick_reg;
  logic                  rollover_reg;

  assign advance      = count_en & (presc_reg == PRESC_LAST);
  assign inc_chain[0] = advance;

  // Prescaler holds while paused so a resumed count finishes the partial second.
  always_ff @(posedge clk) begin
    if (!rst_n || !clr_n) begin
      presc_reg <= '0;
    end else if (count_en) begin
      presc_reg <= advance ? '0 : presc_reg + PW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit_cnt #(
        .MAX (digit_max(gi))
      ) u_digit (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~clr_n),
        .inc   (inc_chain[gi]),
        .q     (digit_q[gi]),
        .carry (inc_chain[gi+1])
      );
      assign live_bcd[gi*DIGIT_W +: DIGIT_W] = digit_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n || !clr_n) begin
      disp_reg     <= '0;
      sec_tick_reg <= 1'b0;
      rollover_reg <= 1'b0;
    end else begin
      if (!lap) begin
        disp_reg <= live_bcd;
      end
      sec_tick_reg <= advance;
      // Carry out of the minutes-tens digit only happens on 59:59 -> 00:00.
      rollover_reg <= inc_chain[NUM_DIGITS];
    end
  end

  assign disp_bcd = disp_reg;
  assign sec_tick = sec_tick_reg;
  assign rollover = rollover_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Randomised and directed bench for stopwatch_counter, two instances
// (TICK_DIV=4 and TICK_DIV=1) checked every cycle against a seconds-based model.
module tb_stopwatch_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        count_en = 1'b0;
  logic        lap = 1'b0;
  logic        clr_n = 1'b1;
  logic [15:0] live4, disp4, live1, disp1;
  logic        tick4, roll4, tick1, roll1;

  always #5 clk = ~clk;

  stopwatch_counter #(.TICK_DIV(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (count_en),
    .lap      (lap),
    .clr_n    (clr_n),
    .live_bcd (live4),
    .disp_bcd (disp4),
    .sec_tick (tick4),
    .rollover (roll4)
  );

  stopwatch_counter #(.TICK_DIV(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (count_en),
    .lap      (lap),
    .clr_n    (clr_n),
    .live_bcd (live1),
    .disp_bcd (disp1),
    .sec_tick (tick1),
    .rollover (roll1)
  );

  // Reference model keeps elapsed time as a plain number of seconds.
  typedef struct {
    int secs;
    int presc;
    int disp;
    bit tick;
    bit roll;
  } model_t;

  model_t m4, m1;
  int n_checks = 0;
  int n_fail   = 0;
  int ticks4 = 0, ticks1 = 0, rolls1 = 0, roll_at_tick = -1;

  function automatic model_t step(input model_t m, input int td, input bit rs,
                                  input bit cl, input bit en, input bit lp);
    model_t n;
    n = m;
    n.tick = 1'b0;
    n.roll = 1'b0;
    if (!rs || !cl) begin
      n.secs = 0;
      n.presc = 0;
      n.disp = 0;
      return n;
    end
    if (!lp) n.disp = m.secs;
    if (en) begin
      if (m.presc == td - 1) begin
        n.presc = 0;
        n.tick = 1'b1;
        if (m.secs == 3599) begin
          n.secs = 0;
          n.roll = 1'b1;
        end else begin
          n.secs = m.secs + 1;
        end
      end else begin
        n.presc = m.presc + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit rs, input bit cl, input bit en, input bit lp);
    @(negedge clk);
    rst_n = rs;
    clr_n = cl;
    count_en = en;
    lap = lp;
    @(posedge clk);
    m4 = step(m4, 4, rs, cl, en, lp);
    m1 = step(m1, 1, rs, cl, en, lp);
    #1;
    check("live4", 32'(live4), 32'(bcd(m4.secs)));
    check("disp4", 32'(disp4), 32'(bcd(m4.disp)));
    check("tick4", 32'(tick4), 32'(m4.tick));
    check("roll4", 32'(roll4), 32'(m4.roll));
    check("live1", 32'(live1), 32'(bcd(m1.secs)));
    check("disp1", 32'(disp1), 32'(bcd(m1.disp)));
    check("tick1", 32'(tick1), 32'(m1.tick));
    check("roll1", 32'(roll1), 32'(m1.roll));
    if (tick4) ticks4++;
    if (tick1) ticks1++;
    if (roll1) begin
      rolls1++;
      roll_at_tick = tick1 ? ticks1 : -1;
    end
  endtask

  task automatic do_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    ticks4 = 0;
    ticks1 = 0;
    rolls1 = 0;
    roll_at_tick = -1;
  endtask

  initial begin
    m4 = '{0, 0, 0, 1'b0, 1'b0};
    m1 = '{0, 0, 0, 1'b0, 1'b0};
    do_reset();
    check("reset_live", 32'(live4), 32'h0);
    check("reset_disp", 32'(disp4), 32'h0);

    // Reset mid-count at 00:07
    for (int i = 0; i < 29; i++) cyc(1, 1, 1, 0);
    check("t1_live_pre", 32'(live4), 32'h0007);
    cyc(0, 1, 1, 0);
    check("t1_live", 32'(live4), 32'h0);
    check("t1_disp", 32'(disp4), 32'h0);
    check("t1_tick", 32'(tick4), 32'h0);
    cyc(0, 1, 1, 0);
    $display("test1 reset mid-count: live=%h disp=%h", live4, disp4);

    // 40 enabled cycles -> 10 seconds
    do_reset();
    for (int i = 0; i < 40; i++) cyc(1, 1, 1, 0);
    check("t2_ticks", 32'(ticks4), 32'd10);
    check("t2_live", 32'(live4), 32'h0010);
    cyc(1, 1, 0, 0);
    check("t2_disp", 32'(disp4), 32'h0010);
    $display("test2 40 cycles: live=%h disp=%h ticks=%0d", live4, disp4, ticks4);

    // Pause resumes mid-second
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 1, 1, 0);
    check("t3_ticks", 32'(ticks4), 32'd2);
    check("t3_live", 32'(live4), 32'h0002);
    $display("test3 pause/resume: live=%h ticks=%0d", live4, ticks4);

    // Lap freezes the display while live keeps counting
    do_reset();
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 1);
    check("t4_disp_frozen", 32'(disp4), 32'h0003);
    check("t4_live", 32'(live4), 32'h0008);
    cyc(1, 1, 0, 0);
    check("t4_disp_release", 32'(disp4), 32'h0008);
    $display("test4 lap: live=%h disp=%h", live4, disp4);

    // TICK_DIV=1 full hour with rollover
    do_reset();
    for (int i = 0; i < 3600; i++) begin
      cyc(1, 1, 1, 0);
      if (i == 59)  check("t5_carry_0059", 32'(live1), 32'h0100);
      if (i == 599) check("t5_carry_0959", 32'(live1), 32'h1000);
    end
    check("t5_live", 32'(live1), 32'h0000);
    check("t5_rolls", 32'(rolls1), 32'd1);
    check("t5_roll_tick", 32'(roll_at_tick), 32'd3600);
    $display("test5 hour: live=%h rollovers=%0d at tick %0d", live1, rolls1, roll_at_tick);

    // Clear while lapped and counting
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0);
    for (int i = 0; i < 2; i++) cyc(1, 1, 1, 1);
    check("t6_live_pre", 32'(live4), 32'h0005);
    cyc(1, 0, 1, 1);
    check("t6_live_clr", 32'(live4), 32'h0);
    check("t6_disp_clr", 32'(disp4), 32'h0);
    ticks4 = 0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
    check("t6_no_early_tick", 32'(ticks4), 32'd0);
    cyc(1, 1, 1, 0);
    check("t6_tick", 32'(tick4), 32'd1);
    check("t6_live", 32'(live4), 32'h0001);
    $display("test6 clear under lap: live=%h disp=%h", live4, disp4);

    // Random level stimulus
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 127) != 0), ($urandom_range(0, 63) != 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end
    $display("random 4000 cycles: live4=%h live1=%h", live4, live1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
